// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parameterised VGA raster timing generator.
//
// Free-running sx/sy raster counters advance on pix_clk when ce=1. A frame
// counter counts completed frames. Visible-area, line and frame strobes are
// decoded straight from the registered counters (zero latency). hsync/vsync
// and a delayed copy of de pass through a PIPE_DLY-deep delay line, so they
// line up with a pixel datapath that is PIPE_DLY ce-cycles deep.
//
// Ports:
//   pix_clk     in   pixel clock (only clock)
//   rst_n       in   asynchronous active-low reset
//   ce          in   pixel enable; all state holds while ce=0
//   sx, sy      out  current column / line (registered)
//   de          out  visible-area flag, undelayed
//   line_start  out  sx==0, undelayed
//   frame_start out  sx==0 && sy==0, undelayed
//   hsync/vsync out  sync pins, delayed PIPE_DLY ce-cycles, polarity per param
//   de_dly      out  de delayed PIPE_DLY ce-cycles
//   frame_cnt   out  completed-frame count, wraps at 2^FRAME_CNT_W
module vga_timing_gen #(
  parameter int H_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH  = 16,
  parameter int H_SYNC_PULSE   = 96,
  parameter int H_BACK_PORCH   = 48,
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33,
  parameter int H_SYNC_POL     = 0,
  parameter int V_SYNC_POL     = 0,
  parameter int PIPE_DLY       = 2,
  parameter int FRAME_CNT_W    = 16,
  localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic                   pix_clk,
  input  logic                   rst_n,
  input  logic                   ce,
  output logic [HW-1:0]          sx,
  output logic [VW-1:0]          sy,
  output logic                   de,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de_dly,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  // All decode compares are done at counter width.
  localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE_AREA);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE_AREA);
  localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE - 1);
  localparam logic          HPOL   = 1'(H_SYNC_POL);
  localparam logic          VPOL   = 1'(V_SYNC_POL);

  generate
    if (H_TOTAL < 4 || PIPE_DLY < 0 || PIPE_DLY > 8 || FRAME_CNT_W < 1) begin : g_bad_param
      $error("vga_timing_gen: H_TOTAL must be >= 4, PIPE_DLY in 0..8, FRAME_CNT_W >= 1");
    end
  endgenerate

  // Raster counters; sy only moves on the sx wrap, frame_cnt on the sy wrap.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      sx        <= '0;
      sy        <= '0;
      frame_cnt <= '0;
    end else if (ce) begin
      if (sx == H_MAX) begin
        sx <= '0;
        if (sy == V_MAX) begin
          sy        <= '0;
          frame_cnt <= frame_cnt + 1'b1;
        end else begin
          sy <= sy + 1'b1;
        end
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

  logic hs_act, vs_act;

  assign de          = (sx < H_VIS) && (sy < V_VIS);
  assign line_start  = (sx == '0);
  assign frame_start = (sx == '0) && (sy == '0);
  assign hs_act      = (sx >= HS_BEG) && (sx <= HS_END);
  // vs_act decodes sy only, so vsync edges fall on sx==0.
  assign vs_act      = (sy >= VS_BEG) && (sy <= VS_END);

  // Delay line carries active flags {hs, vs, de}; polarity is applied at the
  // output so a flushed (zero) stage always reads as inactive.
  logic [2:0] raw_v, dly_v;
  assign raw_v = {hs_act, vs_act, de};

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign dly_v = raw_v;
    end else begin : g_pipe
      logic [PIPE_DLY-1:0][2:0] dly_pipe;
      always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_pipe <= '0;
        end else if (ce) begin
          dly_pipe[0] <= raw_v;
          for (int i = 1; i < PIPE_DLY; i++) dly_pipe[i] <= dly_pipe[i-1];
        end
      end
      assign dly_v = dly_pipe[PIPE_DLY-1];
    end
  endgenerate

  assign hsync  = dly_v[2] ? HPOL : ~HPOL;
  assign vsync  = dly_v[1] ? VPOL : ~VPOL;
  assign de_dly = dly_v[0];

endmodule
